vjtag_led_engine: RTL and testbench
===================================

// Module: vjtag_led_engine
// PURPOSE
//  Downstream stage of the virtual-JTAG client, in the board clock domain.
//  Receives each 7-bit DR word committed on Update-DR, signalled by a toggle,
//  and resynchronises it. Decodes it as an LED command and animates 3 board
//  LEDs (static, blink, chase, PWM dim) from a free-running prescaler.
//  Counts accepted commands for host-side sanity checks.
// PARAMETERS
//  PRESCALE_W   24  prescaler width; tick period base (min 4)
//  SYNC_STAGES  2   flops in upd_toggle synchroniser (min 2)
//  CNT_W        8   width of cmd_count
// PORTS
//  clk         in   1              board clock; all logic on rising edge
//  reset       in   1              async, active-high
//  upd_toggle  in   1              from tck domain; flips once per Update-DR
//  dr_word     in   7              committed DR; stable >= SYNC_STAGES+3 clk after flip
//  leds        out  3              LED drive, 1 = on
//  cmd_count   out  CNT_W          accepted commands, wraps
//  readback    out  7              status word (VJTAG_LED_READBACK_EN only)
// BEHAVIOUR
//  Reset: leds=0, cmd_count=0, mode=STATIC, pattern=0, arg=0, prescaler=0,
//   sync flops=0, armed=0, readback=0. Reset mid-animation aborts at once.
//  Sync: upd_toggle -> SYNC_STAGES flops -> prev flop; edge = sync_out ^ prev.
//   armed sets SYNC_STAGES+1 clk after reset release; edges ignored until
//   armed. A high upd_toggle at reset release is never accepted.
//  Accept: on edge, capture dr_word into cmd; next clk decode and update state.
//   leds show new command exactly SYNC_STAGES+3 rising edges after the
//   upd_toggle change (first edge sampling it = edge 1).
//  Upstream must space flips >= SYNC_STAGES+3 clk; closer flips are undefined.
//  Decode: op=cmd[6:5], arg=cmd[4:3], pattern=cmd[2:0].
//   00 STATIC  leds=pattern; arg ignored.
//   01 BLINK   leds start=pattern; each tick alternate pattern <-> 3'b000.
//   10 CHASE   leds start=pattern; each tick rotate left 1 (bit2->bit0).
//              pattern 000 stays 000.
//   11 PWM     leds = pattern when prescaler[1:0] < arg, else 000.
//              duty 0/25/50/75%; arg=0 -> always off.
//  Mode FSM: STATIC/BLINK/CHASE/PWM; changes only on accepted command;
//   any mode -> any mode; same mode re-accepted restarts animation.
//  Prescaler: PRESCALE_W-bit up-counter, wraps; cleared on every accept.
//   tick when low (PRESCALE_W-3+arg) bits all ones.
//   Period = 2^(PRESCALE_W-3+arg) clk.
//  Accept and tick same cycle: command wins, tick dropped.
//  cmd_count +1 per accept; max -> 0 wraps silently.
// CONFIGURATION
//  VJTAG_LED_READBACK_EN defined: readback = {mode[1:0], arg[1:0], leds[2:0]},
//   registered, one clk behind leds. Host reads it via a capture DR.
//  Not defined: readback tied to 7'd0, no extra flops; all else identical.
// TESTING (PRESCALE_W=4, SYNC_STAGES=2, CNT_W=8)
//  Hold upd_toggle=1 through reset release, wait 10 clk -> leds=000,
//   cmd_count=0.
//  dr_word=7'b00_00_101, flip toggle -> leds=101 on 5th edge, not 4th;
//   cmd_count=1.
//  dr_word=7'b01_00_011 -> leds alternate 011/000, each held 2 clk.
//  dr_word=7'b10_01_001 -> 001,010,100,001, each held 4 clk.
//  dr_word=7'b11_10_111 -> 111 for 2 of every 4 clk. Then 7'b11_00_111 -> 000.
//  256 accepts -> cmd_count=0. With macro, after 7'b10_01_001,
//   readback=7'b10_01_001 then tracks rotation.
//  Without macro, readback=0 always.
//  Assert reset mid-BLINK -> leds=000 immediately.
//  After release, stale dr_word not accepted until next toggle flip.

Source files
------------

// File: rtl/vjtag_led_engine_if.sv
// Bundle between the virtual-JTAG client and the LED engine:
// the toggle/DR inputs and the LED, count and readback outputs.
interface vjtag_led_engine_if #(
    parameter int CNT_W = 8
);
    logic             upd_toggle;
    logic [6:0]       dr_word;
    logic [2:0]       leds;
    logic [CNT_W-1:0] cmd_count;
    logic [6:0]       readback;

    modport master (
        output upd_toggle, dr_word,
        input  leds, cmd_count, readback
    );

    modport slave (
        input  upd_toggle, dr_word,
        output leds, cmd_count, readback
    );
endinterface

// File: rtl/vjtag_led_engine.sv
// Virtual-JTAG LED engine: resyncs Update-DR toggle, decodes LED commands.
// Optional VJTAG_LED_READBACK_EN adds a registered status readback word.
module vjtag_led_engine #(
    parameter int PRESCALE_W  = 24,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    vjtag_led_engine_if.slave bus
);
    typedef enum logic [1:0] {
        ST_STATIC = 2'b00,
        ST_BLINK  = 2'b01,
        ST_CHASE  = 2'b10,
        ST_PWM    = 2'b11
    } mode_e;

    mode_e                  r_mode;
    mode_e                  w_mode_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [SYNC_STAGES:0]   r_arm;
    logic                   w_edge;
    logic                   w_accept;
    logic                   r_cap;
    logic [6:0]             r_cmd;
    logic                   r_load;
    logic [1:0]             r_arg;
    logic [2:0]             r_pat;
    logic [2:0]             r_leds;
    logic [2:0]             w_leds_nxt;
    logic [PRESCALE_W-1:0]  r_pre;
    logic [PRESCALE_W-1:0]  w_pre_nxt;
    logic [PRESCALE_W-1:0]  w_mask;
    logic [7:0]             w_sh;
    logic                   w_tick;
    logic [CNT_W-1:0]       r_cnt;

    assign w_edge   = r_sync[SYNC_STAGES-1] ^ r_prev;
    assign w_accept = w_edge & r_arm[SYNC_STAGES];

    // Toggle resync; r_arm masks the fill of the chain after reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_arm  <= '0;
            r_cap  <= 1'b0;
            r_cmd  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.upd_toggle};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_arm  <= {r_arm[SYNC_STAGES-1:0], 1'b1};
            r_cap  <= w_accept;
            if (w_accept) begin
                r_cmd <= bus.dr_word;
            end
        end
    end

    always_comb begin
        w_mode_nxt = r_mode;
        if (r_cap) begin
            w_mode_nxt = mode_e'(r_cmd[6:5]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode <= ST_STATIC;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_load <= 1'b0;
            r_arg  <= '0;
            r_pat  <= '0;
            r_cnt  <= '0;
        end else begin
            r_load <= r_cap;
            if (r_cap) begin
                r_arg <= r_cmd[4:3];
                r_pat <= r_cmd[2:0];
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Tick period 2^(PRESCALE_W-3+arg); a full-width shift yields an all-ones mask
    assign w_sh      = 8'(PRESCALE_W - 3) + {6'd0, r_arg};
    assign w_mask    = ~({PRESCALE_W{1'b1}} << w_sh);
    assign w_tick    = ((r_pre & w_mask) == w_mask);
    assign w_pre_nxt = r_load ? '0 : r_pre + 1'b1;

    always_comb begin
        w_leds_nxt = r_leds;
        unique case (r_mode)
            ST_STATIC: w_leds_nxt = r_pat;
            ST_BLINK: begin
                if (r_load) begin
                    w_leds_nxt = r_pat;
                end else if (w_tick) begin
                    w_leds_nxt = (r_leds == 3'b000) ? r_pat : 3'b000;
                end
            end
            ST_CHASE: begin
                if (r_load) begin
                    w_leds_nxt = r_pat;
                end else if (w_tick) begin
                    w_leds_nxt = {r_leds[1:0], r_leds[2]};
                end
            end
            ST_PWM: begin
                w_leds_nxt = (w_pre_nxt[1:0] < r_arg) ? r_pat : 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre  <= '0;
            r_leds <= '0;
        end else begin
            r_pre  <= w_pre_nxt;
            r_leds <= w_leds_nxt;
        end
    end

    assign bus.leds      = r_leds;
    assign bus.cmd_count = r_cnt;

`ifdef VJTAG_LED_READBACK_EN
    logic [6:0] r_rb;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rb <= '0;
        end else begin
            r_rb <= {r_mode, r_arg, r_leds};
        end
    end

    assign bus.readback = r_rb;
`else
    assign bus.readback = 7'd0;
`endif
endmodule

// File: tb/tb_vjtag_led_engine.sv
// Scoreboard bench for vjtag_led_engine (PRESCALE_W=4, SYNC_STAGES=2).
// Expected LED/readback words are queued at drive time, popped per negedge.
module tb_vjtag_led_engine;
    logic clk;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] exp_cnt = '0;

`ifdef VJTAG_LED_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    typedef struct {
        int         idx;
        bit         chk;
        logic [2:0] leds;
        bit         chk_rb;
        logic [6:0] rb;
    } exp_t;

    exp_t exp_q[$];

    vjtag_led_engine_if #(.CNT_W(8)) vif ();

    vjtag_led_engine #(
        .PRESCALE_W (4),
        .SYNC_STAGES(2),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour, t = clocks since the new command reached the LEDs
    function automatic logic [2:0] model(input logic [6:0] w, input int t);
        logic [2:0] pat;
        logic [2:0] r;
        int         p;
        pat = w[2:0];
        p   = 2 << w[4:3];
        r   = pat;
        case (w[6:5])
            2'b00: r = pat;
            2'b01: r = (((t / p) % 2) == 0) ? pat : 3'b000;
            2'b10: for (int k = 0; k < ((t / p) % 3); k++) r = {r[1:0], r[2]};
            default: r = ((t % 4) < int'(w[4:3])) ? pat : 3'b000;
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) check($sformatf("leds%0d", e.idx), 32'(vif.leds), 32'(e.leds));
            if (e.chk_rb) check($sformatf("rb%0d", e.idx), 32'(vif.readback), 32'(e.rb));
        end
    end

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (exp_q.size() > 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic send(input logic [6:0] w, input int ncyc,
                        input bit chk_old, input logic [2:0] old);
        exp_t e;
        @(posedge clk);
        #1;
        vif.dr_word    = w;
        vif.upd_toggle = ~vif.upd_toggle;
        exp_cnt++;
        for (int k = 0; k < 5; k++) begin
            e.idx    = k;
            e.chk    = (k == 4) && chk_old;
            e.leds   = old;
            e.chk_rb = 1'b0;
            e.rb     = '0;
            exp_q.push_back(e);
        end
        for (int t = 0; t < ncyc; t++) begin
            e.idx    = 5 + t;
            e.chk    = 1'b1;
            e.leds   = model(w, t);
            e.chk_rb = RB ? (t >= 1) : 1'b1;
            e.rb     = RB ? {w[6:3], model(w, (t > 0) ? t - 1 : 0)} : 7'd0;
            exp_q.push_back(e);
        end
        drain();
        check("cmd_count", 32'(vif.cmd_count), 32'(exp_cnt));
    endtask

    task automatic do_reset(input int cycles);
        reset   = 1'b1;
        exp_cnt = '0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        vif.upd_toggle = 1'b1;
        vif.dr_word    = 7'b00_00_111;
        do_reset(3);
        repeat (10) @(negedge clk);
        check("rst_leds", 32'(vif.leds), 32'd0);
        check("rst_cnt", 32'(vif.cmd_count), 32'd0);
        check("rst_rb", 32'(vif.readback), 32'd0);

        send(7'b00_00_101, 8, 1'b1, 3'b000);
        send(7'b01_00_011, 12, 1'b1, 3'b101);
        send(7'b10_01_001, 16, 1'b0, 3'b000);
        send(7'b11_10_111, 12, 1'b0, 3'b000);
        send(7'b11_00_111, 8, 1'b0, 3'b000);
        send(7'b10_00_110, 10, 1'b0, 3'b000);
        send(7'b11_11_010, 8, 1'b0, 3'b000);
        send(7'b01_01_110, 16, 1'b0, 3'b000);
        send(7'b01_01_110, 8, 1'b0, 3'b000);

        send(7'b01_00_011, 5, 1'b0, 3'b000);
        #2;
        check("pre_rst_leds", 32'(vif.leds), 32'(3'b011));
        reset = 1'b1;
        #1;
        check("mid_rst_leds", 32'(vif.leds), 32'd0);
        check("mid_rst_cnt", 32'(vif.cmd_count), 32'd0);
        exp_cnt     = '0;
        vif.dr_word = 7'b00_00_111;
        do_reset(2);
        repeat (20) @(negedge clk);
        check("stale_leds", 32'(vif.leds), 32'd0);
        check("stale_cnt", 32'(vif.cmd_count), 32'd0);
        send(7'b00_00_010, 4, 1'b1, 3'b000);

        do_reset(2);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] iv;
            iv = 8'(i);
            send({4'b0000, iv[2:0]}, 2, 1'b0, 3'b000);
        end
        check("wrap_cnt", 32'(vif.cmd_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
